multi_zone_alarm_ctrl: RTL



---
 rtl/multi_zone_alarm_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/multi_zone_alarm_ctrl.sv
// N-zone alarm controller: synchronised inputs, per-zone persistence filter, arm/alarm FSM,
// chaser LEDs, pulsed buzzer and call request. Define ZONE_LATCH_EN for latching zones.
module multi_zone_alarm_ctrl #(
  parameter int unsigned       NZones      = 4,
  parameter int unsigned       LedW        = 8,
  parameter int unsigned       PersistCyc  = 2_000_000,
  parameter int unsigned       DebounceCyc = 400_000,
  parameter int unsigned       StepCyc     = 4_000_000,
  parameter logic [NZones-1:0] CallMask    = {NZones{1'b1}}
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              arm_btn_i,
  input  logic              remote_toggle_i,
  input  logic              ack_i,
  input  logic [NZones-1:0] sensor_i,
  output logic [LedW-1:0]   led_o,
  output logic              buzzer_o,
  output logic              armed_o,
  output logic              armed_led_o,
  output logic              alarm_active_o,
  output logic [NZones-1:0] zone_latched_o,
  output logic              sim_o
);

  localparam int unsigned PersistW  = $clog2(PersistCyc + 1);
  localparam int unsigned DebounceW = (DebounceCyc > 0) ? $clog2(DebounceCyc + 1) : 1;
  localparam int unsigned StepW     = (StepCyc > 1) ? $clog2(StepCyc) : 1;
  localparam int unsigned IdxW      = (LedW > 1) ? $clog2(LedW) : 1;
  localparam logic [PersistW-1:0] PersistMax = PersistW'(PersistCyc);

  typedef enum logic [1:0] {StDisarmed, StArmedIdle, StAlarm, StSilenced} state_e;

  // Sync chains: [0] first stage, [1] synced value, [2] previous synced value for edges.
  logic [2:0]           arm_sync_q, rem_sync_q;
  logic [1:0]           ack_sync_q;
  logic [NZones-1:0]    sen_s1_q, sen_s2_q;
  logic [PersistW-1:0]  cnt_q [NZones];
  logic [PersistW-1:0]  cnt_d [NZones];
  logic [NZones-1:0]    q_q, q_d;
  logic [DebounceW-1:0] lock_q, lock_d;
  state_e               state_q, state_d;
  logic [NZones-1:0]    latched_q, latched_d;
  logic [StepW-1:0]     step_q, step_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 buzzer_q, buzzer_d;
  logic [LedW-1:0]      led_q, led_d;
  logic                 armed_q, armed_d, alarm_q, alarm_d, sim_q, sim_d;

  logic ack_s, btn_acc, tog, filt_clr, new_zone, run;

  assign ack_s    = ack_sync_q[1];
  assign btn_acc  = arm_sync_q[2] & ~arm_sync_q[1] & (lock_q == '0);
  assign tog      = btn_acc | (rem_sync_q[2] ^ rem_sync_q[1]);
  assign filt_clr = tog && (state_q != StDisarmed);
  assign new_zone = |(q_q & ~latched_q);

  always_comb begin
    lock_d = lock_q;
    if (btn_acc) begin
      lock_d = DebounceW'(DebounceCyc);
    end else if (lock_q != '0) begin
      lock_d = lock_q - DebounceW'(1);
    end
    for (int i = 0; i < NZones; i++) begin
      cnt_d[i] = cnt_q[i];
      if (filt_clr || !sen_s2_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != PersistMax) begin
        cnt_d[i] = cnt_q[i] + PersistW'(1);
      end
      q_d[i] = !filt_clr && (cnt_q[i] == PersistMax);
    end
  end

  always_comb begin
    state_d = state_q;
    if (tog) begin
      state_d = (state_q == StDisarmed) ? StArmedIdle : StDisarmed;
    end else begin
      unique case (state_q)
        StDisarmed:  state_d = StDisarmed;
        StArmedIdle: if (|q_q) state_d = StAlarm;
`ifdef ZONE_LATCH_EN
        StAlarm:     if (ack_s) state_d = StSilenced;
        StSilenced: begin
          if (new_zone)               state_d = StAlarm;
          else if (ack_s && q_q == '0) state_d = StArmedIdle;
        end
`else
        StAlarm: begin
          if (q_q == '0) state_d = StArmedIdle;
          else if (ack_s) state_d = StSilenced;
        end
        StSilenced: begin
          if (q_q == '0)    state_d = StArmedIdle;
          else if (new_zone) state_d = StAlarm;
        end
`endif
        default: state_d = StArmedIdle;
      endcase
    end

`ifdef ZONE_LATCH_EN
    latched_d = latched_q;
    if (tog || (state_q == StSilenced && state_d == StArmedIdle)) begin
      latched_d = '0;
    end else if (state_q != StDisarmed) begin
      latched_d = latched_q | q_q;
    end
`else
    latched_d = (state_d == StDisarmed) ? '0 : q_q;
`endif
  end

  // Chaser and buzzer restart from zero on every entry into ALARM.
  always_comb begin
    run      = (state_q == StAlarm) && (state_d == StAlarm);
    step_d   = '0;
    idx_d    = '0;
    buzzer_d = 1'b0;
    if (run) begin
      step_d   = step_q + StepW'(1);
      idx_d    = idx_q;
      buzzer_d = buzzer_q;
      if (step_q == StepW'(StepCyc - 1)) begin
        step_d   = '0;
        buzzer_d = ~buzzer_q;
        idx_d    = (idx_q == IdxW'(LedW - 1)) ? '0 : idx_q + IdxW'(1);
      end
    end

    led_d = '1;
    if (state_q == StAlarm) begin
      led_d = ~(LedW'(1) << idx_q);
    end else if (state_q == StSilenced) begin
      led_d[NZones-1:0] = ~latched_q;
    end

    armed_d = (state_d != StDisarmed);
    alarm_d = (state_d == StAlarm);
    sim_d   = ((state_d == StAlarm) || (state_d == StSilenced)) && |(latched_d & CallMask);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      arm_sync_q <= 3'b111;
      rem_sync_q <= '0;
      ack_sync_q <= '0;
      sen_s1_q   <= '0;
      sen_s2_q   <= '0;
      for (int i = 0; i < NZones; i++) cnt_q[i] <= '0;
      q_q        <= '0;
      lock_q     <= '0;
      state_q    <= StArmedIdle;
      latched_q  <= '0;
      step_q     <= '0;
      idx_q      <= '0;
      buzzer_q   <= 1'b0;
      led_q      <= '1;
      armed_q    <= 1'b1;
      alarm_q    <= 1'b0;
      sim_q      <= 1'b0;
    end else begin
      arm_sync_q <= {arm_sync_q[1:0], arm_btn_i};
      rem_sync_q <= {rem_sync_q[1:0], remote_toggle_i};
      ack_sync_q <= {ack_sync_q[0], ack_i};
      sen_s1_q   <= sensor_i;
      sen_s2_q   <= sen_s1_q;
      for (int i = 0; i < NZones; i++) cnt_q[i] <= cnt_d[i];
      q_q        <= q_d;
      lock_q     <= lock_d;
      state_q    <= state_d;
      latched_q  <= latched_d;
      step_q     <= step_d;
      idx_q      <= idx_d;
      buzzer_q   <= buzzer_d;
      led_q      <= led_d;
      armed_q    <= armed_d;
      alarm_q    <= alarm_d;
      sim_q      <= sim_d;
    end
  end

  assign led_o          = led_q;
  assign buzzer_o       = buzzer_q;
  assign armed_o        = armed_q;
  assign armed_led_o    = armed_q;
  assign alarm_active_o = alarm_q;
  assign zone_latched_o = latched_q;
  assign sim_o          = sim_q;

endmodule
